paddle_ball_engine: RTL and testbench

//  Parametrised game-state engine for the paddle-and-ball LED game on an N x M matrix.

---
 rtl/paddle_ball_engine.sv | 143 ++++++++++++++
 tb/tb_paddle_ball_engine.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/paddle_ball_engine.sv
// Game-state engine for the paddle-and-ball LED game: paddle, ball flight,
// wall/paddle bounces, misses, lives and saturating score.
module paddle_ball_engine #(
  parameter  int GRID_W   = 8,
  parameter  int GRID_H   = 8,
  parameter  int PADDLE_W = 3,
  parameter  int BALL_DIV = 6,
  parameter  int LIVES    = 3,
  parameter  int SCORE_W  = 8,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(LIVES+1)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               step_en,
  input  logic               left,
  input  logic               right,
  input  logic               throw,
  input  logic               restart,
  output logic [XW-1:0]      paddle_x,
  output logic [XW-1:0]      ball_x,
  output logic [YW-1:0]      ball_y,
  output logic               held,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [LW-1:0]      lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);
  localparam int DW     = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;
  localparam int PX_MAX = GRID_W - PADDLE_W;
  localparam int PX_RST = (GRID_W - PADDLE_W) / 2;
  localparam int HALF   = PADDLE_W / 2;

  typedef enum logic [1:0] {S_HELD, S_FLIGHT, S_OVER} state_t;

  state_t              st_q, st_d;
  logic [XW-1:0]       px_q, px_d, bx_q, bx_d, px_new;
  logic [YW-1:0]       by_q, by_d;
  logic signed [1:0]   dx_q, dx_d, ndx;
  logic                up_q, up_d, do_h, covered, mv_l, mv_r;
  logic [LW-1:0]       lives_q, lives_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [DW-1:0]       div_q, div_d;
  logic                hit_q, hit_d, miss_q, miss_d;

  assign mv_l    = left & ~right;
  assign mv_r    = right & ~left;
  // Paddle check always looks at the paddle position from before this step.
  assign covered = (int'(bx_q) >= int'(px_q)) && (int'(bx_q) <= int'(px_q) + PADDLE_W - 1);

  always_comb begin
    st_d = st_q; px_d = px_q; bx_d = bx_q; by_d = by_q; dx_d = dx_q; up_d = up_q;
    lives_d = lives_q; score_d = score_q; div_d = div_q;
    hit_d = 1'b0; miss_d = 1'b0;
    ndx = dx_q; do_h = 1'b0;
    px_new = px_q;
    if (mv_l && px_q != '0)                     px_new = px_q - 1'b1;
    else if (mv_r && int'(px_q) < PX_MAX)       px_new = px_q + 1'b1;

    if (restart) begin
      st_d = S_HELD; px_d = XW'(PX_RST); bx_d = XW'(PX_RST + HALF); by_d = YW'(1);
      dx_d = 2'sd0; up_d = 1'b1; lives_d = LW'(LIVES); score_d = '0; div_d = '0;
    end else if (step_en) begin
      case (st_q)
        S_HELD: begin
          px_d = px_new;
          bx_d = px_new + XW'(HALF);
          by_d = YW'(1);
          if (throw) begin
            st_d  = S_FLIGHT;
            div_d = '0;
            dx_d  = mv_r ? 2'sd1 : (mv_l ? -2'sd1 : 2'sd0);
            up_d  = 1'b1;
          end
        end
        S_FLIGHT: begin
          px_d = px_new;
          if (div_q != DW'(BALL_DIV - 1)) begin
            div_d = div_q + 1'b1;
          end else begin
            div_d = '0;
            do_h  = 1'b1;
            if (up_q) begin
              if (int'(by_q) < GRID_H - 1) by_d = by_q + 1'b1;
              else begin up_d = 1'b0; by_d = by_q - 1'b1; end
            end else if (int'(by_q) > 1) begin
              by_d = by_q - 1'b1;
            end else if (covered) begin
              up_d  = 1'b1;
              by_d  = YW'(2);
              hit_d = 1'b1;
              if (score_q != '1) score_d = score_q + 1'b1;
              if (bx_q == px_q)                             ndx = -2'sd1;
              else if (int'(bx_q) == int'(px_q) + PADDLE_W - 1) ndx = 2'sd1;
            end else begin
              do_h    = 1'b0;
              miss_d  = 1'b1;
              lives_d = lives_q - 1'b1;
              if (lives_q == LW'(1)) st_d = S_OVER;
              else begin
                st_d = S_HELD; bx_d = px_new + XW'(HALF); by_d = YW'(1);
                dx_d = 2'sd0; up_d = 1'b1;
              end
            end
            if (do_h) begin
              // Reflect off side walls before stepping, so the ball never leaves the grid.
              if (ndx == 2'sd1 && int'(bx_q) == GRID_W - 1) ndx = -2'sd1;
              else if (ndx == -2'sd1 && bx_q == '0)         ndx = 2'sd1;
              dx_d = ndx;
              if (ndx == 2'sd1)       bx_d = bx_q + 1'b1;
              else if (ndx == -2'sd1) bx_d = bx_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q <= S_HELD; px_q <= XW'(PX_RST); bx_q <= XW'(PX_RST + HALF); by_q <= YW'(1);
      dx_q <= 2'sd0; up_q <= 1'b1; lives_q <= LW'(LIVES); score_q <= '0; div_q <= '0;
      hit_q <= 1'b0; miss_q <= 1'b0;
    end else begin
      st_q <= st_d; px_q <= px_d; bx_q <= bx_d; by_q <= by_d;
      dx_q <= dx_d; up_q <= up_d; lives_q <= lives_d; score_q <= score_d; div_q <= div_d;
      hit_q <= hit_d; miss_q <= miss_d;
    end
  end

  assign paddle_x   = px_q;
  assign ball_x     = bx_q;
  assign ball_y     = by_q;
  assign held       = (st_q == S_HELD);
  assign game_over  = (st_q == S_OVER);
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign lives      = lives_q;
  assign score      = score_q;
endmodule

// File: tb/tb_paddle_ball_engine.sv
// Randomized bench for paddle_ball_engine against an integer game model.
module tb_paddle_ball_engine;
  localparam int GW = 8, GH = 8, PW = 3, BD = 6, LV = 3, SW = 8;

  logic CLK = 1'b0, RST_N = 1'b0;
  logic step_en = 1'b0, left = 1'b0, right = 1'b0, throw = 1'b0, restart = 1'b0;
  logic [2:0] paddle_x, ball_x, ball_y;
  logic held, hit_pulse, miss_pulse, game_over;
  logic [1:0] lives;
  logic [SW-1:0] score;

  paddle_ball_engine #(.GRID_W(GW), .GRID_H(GH), .PADDLE_W(PW), .BALL_DIV(BD),
                       .LIVES(LV), .SCORE_W(SW)) dut (
    .CLK(CLK), .RST_N(RST_N), .step_en(step_en), .left(left), .right(right),
    .throw(throw), .restart(restart), .paddle_x(paddle_x), .ball_x(ball_x),
    .ball_y(ball_y), .held(held), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .lives(lives), .score(score), .game_over(game_over));

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;
  // Model: mode 0 = ball on paddle, 1 = in flight, 2 = game over.
  int m_mode, m_px, m_bx, m_by, m_dx, m_dy, m_lives, m_score, m_div, m_hit, m_miss;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_px = (GW - PW) / 2; m_bx = m_px + PW / 2; m_by = 1;
    m_dx = 0; m_dy = 1; m_lives = LV; m_score = 0; m_div = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic model_step(input bit se, input bit l, input bit r, input bit t, input bit rs);
    int old_px, nx;
    bit hor;
    m_hit = 0; m_miss = 0;
    if (rs) begin model_reset(); return; end
    if (!se || m_mode == 2) return;
    old_px = m_px;
    if (l && !r && m_px > 0) m_px--;
    else if (r && !l && m_px < GW - PW) m_px++;
    if (m_mode == 0) begin
      m_bx = m_px + PW / 2; m_by = 1;
      if (t) begin
        m_mode = 1; m_div = 0; m_dy = 1;
        m_dx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
      end
      return;
    end
    if (m_div < BD - 1) begin m_div++; return; end
    m_div = 0;
    hor = 1;
    if (m_dy == 1) begin
      if (m_by < GH - 1) m_by++;
      else begin m_dy = -1; m_by--; end
    end else if (m_by > 1) begin
      m_by--;
    end else if (m_bx >= old_px && m_bx <= old_px + PW - 1) begin
      m_dy = 1; m_by = 2; m_hit = 1;
      m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
      if (m_bx == old_px) m_dx = -1;
      else if (m_bx == old_px + PW - 1) m_dx = 1;
    end else begin
      hor = 0; m_miss = 1; m_lives--;
      if (m_lives == 0) m_mode = 2;
      else begin m_mode = 0; m_bx = m_px + PW / 2; m_by = 1; m_dx = 0; m_dy = 1; end
    end
    if (hor) begin
      nx = m_bx + m_dx;
      if (nx < 0 || nx > GW - 1) begin m_dx = -m_dx; nx = m_bx + m_dx; end
      m_bx = nx;
    end
  endtask

  task automatic check_all();
    chk("paddle_x", int'(paddle_x), m_px);
    chk("ball_x", int'(ball_x), m_bx);
    chk("ball_y", int'(ball_y), m_by);
    chk("held", int'(held), (m_mode == 0) ? 1 : 0);
    chk("hit_pulse", int'(hit_pulse), m_hit);
    chk("miss_pulse", int'(miss_pulse), m_miss);
    chk("lives", int'(lives), m_lives);
    chk("score", int'(score), m_score);
    chk("game_over", int'(game_over), (m_mode == 2) ? 1 : 0);
  endtask

  // Drive inputs, let one rising edge pass, then compare against the model.
  task automatic tick(input bit se, input bit l, input bit r, input bit t, input bit rs);
    step_en = se; left = l; right = r; throw = t; restart = rs;
    @(posedge CLK);
    model_step(se, l, r, t, rs);
    #1;
    check_all();
  endtask

  // Steer the paddle toward (or away from) the ball every step, throwing when held.
  task automatic steer(input bit chase);
    int tgt;
    if (chase) tgt = m_bx - 1;
    else tgt = (m_bx < 4) ? GW - PW : 0;
    if (tgt < 0) tgt = 0;
    if (tgt > GW - PW) tgt = GW - PW;
    tick(1'b1, m_px > tgt, m_px < tgt, m_mode == 0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_paddle_x", int'(paddle_x), 2);
    chk("rst_ball_x", int'(ball_x), 3);
    chk("rst_ball_y", int'(ball_y), 1);
    chk("rst_held", int'(held), 1);
    chk("rst_lives", int'(lives), 3);
    chk("rst_score", int'(score), 0);
    chk("rst_game_over", int'(game_over), 0);
    RST_N = 1'b1;

    // Straight throw: ball stays put on the launch step, first move after 6 steps.
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("launch_held", int'(held), 0);
    repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_move_y", int'(ball_y), 1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_move_y", int'(ball_y), 2);
    chk("first_move_x", int'(ball_x), 3);

    // Ball chased by the paddle: many hits, long enough to saturate the score.
    for (int i = 0; i < 26000; i++) steer(1'b1);
    chk("score_saturated", int'(score), 255);

    // Fully random play with occasional restarts.
    for (int i = 0; i < 15000; i++)
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);

    // Dodge the ball until the game ends, then poke inputs that must be ignored.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5000 && m_mode != 2; i++) steer(1'b0);
    chk("over_reached", int'(game_over), 1);
    for (int i = 0; i < 20; i++)
      tick(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, 1'b0);
    chk("over_lives", int'(lives), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_game_over", int'(game_over), 0);
    chk("restart_paddle_x", int'(paddle_x), 2);

    // Async reset in the middle of a flight takes effect before the next edge.
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    check_all();
    repeat (10) tick(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
